rect_pos_ctl: RTL and testbench

- Tear-free position/enable controller for one draw_rect instance.
- Accepts rectangle update requests (x, y, enable) from N_REQ requesters (game FSM, mouse handler, animation) over valid/ready.
- Arbitrates round-robin and holds the winner in a shadow register.
- Commits the shadow to draw_rect's x_pos/y_pos/enable only on the rising edge of vertical blanking, so a rectangle never moves mid-frame.

---
 rtl/rect_pos_ctl_if.sv | 14 +
 rtl/rect_pos_ctl.sv | 158 +++++++++++++++
 tb/tb_rect_pos_ctl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rect_pos_ctl_if.sv
// Request bus between rectangle-update requesters and rect_pos_ctl.
// Coordinates are packed 12 bits per requester, requester i at [12i+11:12i].
interface rect_pos_ctl_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_en;
  logic [N_REQ-1:0]    req_ready;
  logic [12*N_REQ-1:0] req_x;
  logic [12*N_REQ-1:0] req_y;

  modport master (output req_valid, req_x, req_y, req_en, input req_ready);
  modport slave  (input req_valid, req_x, req_y, req_en, output req_ready);
endinterface

// File: rtl/rect_pos_ctl.sv
// Tear-free position/enable controller for one draw_rect: round-robin accepts
// updates into a shadow register and commits them only on the rising edge of vblnk.
//
// state  | meaning
// IDLE   | shadow empty, outputs current
// PEND   | shadow holds an uncommitted update
// COMMIT | one cycle: outputs load from shadow at the end of this cycle
module rect_pos_ctl #(
  parameter int N_REQ       = 3,
  parameter int RECT_WIDTH  = 48,
  parameter int RECT_HEIGHT = 64,
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int INIT_X      = 0,
  parameter int INIT_Y      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vblnk,
  rect_pos_ctl_if.slave       bus,
  output logic [11:0]         x_pos,
  output logic [11:0]         y_pos,
  output logic                enable,
  output logic                pending,
  output logic                frame_commit
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - RECT_WIDTH);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - RECT_HEIGHT);

  typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr, grant_idx;
  logic          grant_any, accept;
  logic          vblnk_d, vblnk_rise;
  logic [11:0]   sel_x, sel_y, cl_x, cl_y;
  logic          sel_en;
  logic [11:0]   sh_x, sh_y, hd_x, hd_y;
  logic          sh_en, hd_en, hd_vld;
  logic          load_shadow, load_hold, do_commit;

  // First valid requester at or after ptr+1, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  assign accept     = grant_any && (state != COMMIT);
  assign vblnk_rise = vblnk & ~vblnk_d;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      bus.req_ready[i] = accept && (grant_idx == PW'(i));
  end

  always_comb begin
    sel_x  = bus.req_x[12*grant_idx +: 12];
    sel_y  = bus.req_y[12*grant_idx +: 12];
    sel_en = bus.req_en[grant_idx];
    cl_x   = (sel_x > X_MAX) ? X_MAX : sel_x;
    cl_y   = (sel_y > Y_MAX) ? Y_MAX : sel_y;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // An accept coinciding with the commit edge is parked in the hold register
  // so the current shadow commits untouched and the new value follows next frame.
  always_comb begin
    state_nx    = state;
    load_shadow = 1'b0;
    load_hold   = 1'b0;
    do_commit   = 1'b0;
    pending     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_shadow = 1'b1;
          state_nx    = PEND;
        end
      end
      PEND: begin
        pending = 1'b1;
        if (vblnk_rise) begin
          state_nx  = COMMIT;
          load_hold = accept;
        end else begin
          load_shadow = accept;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_nx  = hd_vld ? PEND : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d      <= 1'b1;
      ptr          <= PW'(N_REQ - 1);
      sh_x         <= '0;
      sh_y         <= '0;
      sh_en        <= 1'b0;
      hd_x         <= '0;
      hd_y         <= '0;
      hd_en        <= 1'b0;
      hd_vld       <= 1'b0;
      x_pos        <= 12'(INIT_X);
      y_pos        <= 12'(INIT_Y);
      enable       <= 1'b0;
      frame_commit <= 1'b0;
    end else begin
      vblnk_d      <= vblnk;
      frame_commit <= do_commit;
      if (accept) ptr <= grant_idx;
      if (load_shadow) begin
        sh_x  <= cl_x;
        sh_y  <= cl_y;
        sh_en <= sel_en;
      end
      if (load_hold) begin
        hd_x   <= cl_x;
        hd_y   <= cl_y;
        hd_en  <= sel_en;
        hd_vld <= 1'b1;
      end
      if (do_commit) begin
        x_pos  <= sh_x;
        y_pos  <= sh_y;
        enable <= sh_en;
        if (hd_vld) begin
          sh_x   <= hd_x;
          sh_y   <= hd_y;
          sh_en  <= hd_en;
          hd_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_pos_ctl.sv
// Bench for rect_pos_ctl: directed scenarios plus random traffic, all checked
// against a frame-level behavioural model of shadow/commit.
module tb_rect_pos_ctl;
  localparam int N    = 3;
  localparam int RW   = 48;
  localparam int RH   = 64;
  localparam int HA   = 1024;
  localparam int VA   = 768;
  localparam int IX   = 0;
  localparam int IY   = 0;

  logic clk = 1'b0;
  logic rst, vblnk;
  logic [11:0] x_pos, y_pos;
  logic enable, pending, frame_commit;

  always #5 clk = ~clk;

  rect_pos_ctl_if #(.N_REQ(N)) bus ();

  rect_pos_ctl #(
    .N_REQ(N), .RECT_WIDTH(RW), .RECT_HEIGHT(RH), .H_ACTIVE(HA),
    .V_ACTIVE(VA), .INIT_X(IX), .INIT_Y(IY)
  ) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .bus(bus.slave),
    .x_pos(x_pos), .y_pos(y_pos), .enable(enable),
    .pending(pending), .frame_commit(frame_commit)
  );

  logic        rv[N];
  logic [11:0] rx[N], ry[N];
  logic        ren[N];
  bit          auto_rl, chk_on;

  always_comb begin
    bus.req_valid = '0;
    bus.req_en    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]      = rv[i];
      bus.req_en[i]         = ren[i];
      bus.req_x[12*i +: 12] = rx[i];
      bus.req_y[12*i +: 12] = ry[i];
    end
  end

  int checks = 0, errors = 0;
  int fc_cnt;
  logic [N-1:0] last_ready;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Model: a shadow slot plus a "committing" flag carrying the captured value.
  int          m_ptr;
  bit          m_sv, m_inc, m_vprev;
  logic [11:0] m_sx, m_sy, cvx, cvy, ex_x, ex_y;
  bit          m_sen, cven, ex_en, ex_fc;

  function automatic logic [11:0] clampv(logic [11:0] v, int lim);
    return (int'(v) > lim) ? 12'(lim) : v;
  endfunction

  function automatic int model_grant();
    if (m_inc) return -1;
    for (int off = 1; off <= N; off++) begin
      int idx = (m_ptr + off) % N;
      if (rv[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_sv = 0; m_inc = 0; m_vprev = 1;
    ex_x = IX; ex_y = IY; ex_en = 0; ex_fc = 0;
  endtask

  task automatic setreq(int i, int x, int y, bit e);
    rv[i] = 1'b1; rx[i] = 12'(x); ry[i] = 12'(y); ren[i] = e;
  endtask

  task automatic newreq(int i);
    setreq(i, $urandom_range(0, 4095), $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
  endtask

  task automatic cycle();
    int g;
    bit rise, was_inc;
    @(negedge clk);
    g = model_grant();
    last_ready = bus.req_ready;
    if (chk_on) begin
      chk("ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
      chk("pending", pending, m_sv && !m_inc);
      chk("x_pos", x_pos, ex_x);
      chk("y_pos", y_pos, ex_y);
      chk("enable", enable, ex_en);
      chk("frame_commit", frame_commit, ex_fc);
    end
    if (frame_commit === 1'b1) fc_cnt++;
    @(posedge clk);
    if (rst) begin
      model_reset();
      g = -1;
    end else begin
      rise    = vblnk && !m_vprev;
      m_vprev = vblnk;
      was_inc = m_inc;
      ex_fc   = was_inc;
      if (was_inc) begin ex_x = cvx; ex_y = cvy; ex_en = cven; end
      m_inc = rise && m_sv && !was_inc;
      if (m_inc) begin cvx = m_sx; cvy = m_sy; cven = m_sen; m_sv = 0; end
      if (g >= 0) begin
        m_sx = clampv(rx[g], HA - RW); m_sy = clampv(ry[g], VA - RH);
        m_sen = ren[g]; m_sv = 1; m_ptr = g;
      end
    end
    #1;
    if (g >= 0) begin
      if (auto_rl) newreq(g);
      else rv[g] = 1'b0;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  initial begin
    logic [11:0] last0_x;
    int vcnt;
    rst = 1'b1; vblnk = 1'b1; auto_rl = 0; chk_on = 0; fc_cnt = 0;
    for (int i = 0; i < N; i++) begin rv[i] = 0; rx[i] = 0; ry[i] = 0; ren[i] = 0; end
    model_reset();
    run(2);
    rst = 1'b0; chk_on = 1;
    chk("rst_x", x_pos, IX); chk("rst_y", y_pos, IY); chk("rst_en", enable, 0);
    chk("rst_pend", pending, 0); chk("rst_fc", frame_commit, 0);
    run(4);
    chk("rst_nofc", fc_cnt, 0);

    // single request from requester 1
    vblnk = 0; run(3);
    setreq(1, 100, 200, 1); cycle();
    chk("rr_r1", last_ready, 3'b010);
    run(5);
    chk("pend1", pending, 1); chk("hold_x", x_pos, IX);
    fc_cnt = 0; vblnk = 1; run(3);
    chk("c1_x", x_pos, 100); chk("c1_y", y_pos, 200); chk("c1_en", enable, 1);
    run(3); chk("c1_fc", fc_cnt, 1);

    // all valid continuously: grants 0,1,2,0
    do_reset(); vblnk = 0; run(2);
    auto_rl = 1;
    for (int i = 0; i < N; i++) newreq(i);
    last0_x = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) last0_x = clampv(rx[0], HA - RW);
      cycle();
      chk("rr_seq", last_ready, 1 << (k % 3));
    end
    auto_rl = 0;
    for (int i = 0; i < N; i++) rv[i] = 0;
    vblnk = 1; run(3);
    chk("rr_commit_x", x_pos, last0_x);

    // clamping
    vblnk = 0; run(2); setreq(0, 1020, 760, 1); run(3);
    vblnk = 1; run(3);
    chk("clamp_x", x_pos, 976); chk("clamp_y", y_pos, 704);

    // last accepted wins
    vblnk = 0; run(2); setreq(2, 10, 10, 1); run(2); setreq(2, 20, 30, 1); run(2);
    fc_cnt = 0; vblnk = 1; run(3);
    chk("lw_x", x_pos, 20); chk("lw_y", y_pos, 30);
    vblnk = 0; run(3); vblnk = 1; run(4);
    chk("lw_fc", fc_cnt, 1);

    // accept landing on the vblnk rise while pending
    vblnk = 0; run(2); setreq(0, 300, 300, 1); run(2);
    setreq(1, 400, 400, 0); vblnk = 1; cycle();
    run(2);
    chk("coll_x_old", x_pos, 300); chk("coll_pend", pending, 1);
    vblnk = 0; run(2); vblnk = 1; run(3);
    chk("coll_x_new", x_pos, 400); chk("coll_en_new", enable, 0);

    // reset while pending
    vblnk = 0; run(2); setreq(0, 500, 500, 1); run(2);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rp_pend", pending, 0); chk("rp_x", x_pos, IX); chk("rp_en", enable, 0);
    fc_cnt = 0; vblnk = 1; run(4);
    chk("rp_nofc", fc_cnt, 0);

    // random traffic
    vblnk = 0; vcnt = 5;
    for (int c = 0; c < 3000; c++) begin
      if (vcnt == 0) begin vblnk = ~vblnk; vcnt = $urandom_range(3, 40); end
      else vcnt--;
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 7) == 0) newreq(i);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
